// File: rtl/tl_lamp_driver_if.sv
//------------------------------------------------------------------------------
// tl_lamp_driver_if : phase-code input and lamp outputs of the lamp driver
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tl_lamp_driver_if;
  logic [2:0] i_state;
  logic [2:0] o_ns_lamp;
  logic [2:0] o_ew_lamp;
  logic       o_clear;
  logic       o_fault;

  modport master (
    output i_state,
    input  o_ns_lamp,
    input  o_ew_lamp,
    input  o_clear,
    input  o_fault
  );

  modport slave (
    input  i_state,
    output o_ns_lamp,
    output o_ew_lamp,
    output o_clear,
    output o_fault
  );
endinterface

`default_nettype wire

// File: rtl/tl_lamp_driver.sv
//------------------------------------------------------------------------------
// tl_lamp_driver : phase code to registered lamps, with all-red clearance
//                  before green and yellow flash for START/invalid codes
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tl_lamp_driver #(
  parameter int                   T_WIDTH    = 8,
  parameter logic [T_WIDTH-1:0]   CLR_TIME   = 8'd2,
  parameter logic [T_WIDTH-1:0]   BLINK_HALF = 8'd4
) (
  input  wire logic       i_clk,
  input  wire logic       i_rst,
  tl_lamp_driver_if.slave lamp_bus
);

  localparam logic [1:0] c_mode_rst   = 2'd0;
  localparam logic [1:0] c_mode_run   = 2'd1;
  localparam logic [1:0] c_mode_clear = 2'd2;
  localparam logic [1:0] c_mode_flash = 2'd3;

  localparam logic [T_WIDTH-1:0] c_one          = {{(T_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [T_WIDTH-1:0] c_clr_reload   = CLR_TIME - c_one;
  localparam logic [T_WIDTH-1:0] c_blink_reload = BLINK_HALF - c_one;

  localparam logic [2:0] c_red = 3'b100;
  localparam logic [2:0] c_yel = 3'b010;
  localparam logic [2:0] c_grn = 3'b001;

  logic [1:0]         r_mode;
  logic [2:0]         r_code;
  logic [T_WIDTH-1:0] r_cnt;
  logic               r_phase;
  logic [2:0]         r_ns_lamp;
  logic [2:0]         r_ew_lamp;
  logic               r_clear;
  logic               r_fault;

  logic [1:0]         w_mode_nxt;
  logic [2:0]         w_code_nxt;
  logic [T_WIDTH-1:0] w_cnt_nxt;
  logic               w_phase_nxt;
  logic [2:0]         w_ns_nxt;
  logic [2:0]         w_ew_nxt;
  logic               w_clear_nxt;

  logic w_change;
  logic w_is_green;
  logic w_is_yel;
  logic w_invalid;

  assign w_change   = (r_mode == c_mode_rst) || (lamp_bus.i_state != r_code);
  assign w_is_green = (lamp_bus.i_state == 3'b011) || (lamp_bus.i_state == 3'b000);
  assign w_is_yel   = (lamp_bus.i_state == 3'b010) || (lamp_bus.i_state == 3'b001);
  assign w_invalid  = lamp_bus.i_state[2] && (lamp_bus.i_state != 3'b111);

  // State register; lamps are registered from the next-state decode below.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode    <= c_mode_rst;
      r_code    <= 3'b111;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_ns_lamp <= c_red;
      r_ew_lamp <= c_red;
      r_clear   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_code    <= w_code_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_ns_lamp <= w_ns_nxt;
      r_ew_lamp <= w_ew_nxt;
      r_clear   <= w_clear_nxt;
      r_fault   <= r_fault | w_invalid;
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (w_change) begin
      w_code_nxt = lamp_bus.i_state;
      if (w_is_green) begin
        if (CLR_TIME != '0) begin
          w_mode_nxt = c_mode_clear;
          w_cnt_nxt  = c_clr_reload;
        end else begin
          w_mode_nxt = c_mode_run;
        end
      end else if (w_is_yel) begin
        w_mode_nxt = c_mode_run;
      end else begin
        w_mode_nxt  = c_mode_flash;
        w_cnt_nxt   = c_blink_reload;
        w_phase_nxt = 1'b1;
      end
    end else begin
      case (r_mode)
        c_mode_clear: begin
          if (r_cnt != '0) w_cnt_nxt = r_cnt - c_one;
          else             w_mode_nxt = c_mode_run;
        end
        c_mode_flash: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - c_one;
          end else begin
            w_phase_nxt = ~r_phase;
            w_cnt_nxt   = c_blink_reload;
          end
        end
        default: ;
      endcase
    end
  end

  // Only one approach is ever non-red in RUN, so no green/yellow conflict arises.
  always_comb begin
    w_ns_nxt    = c_red;
    w_ew_nxt    = c_red;
    w_clear_nxt = 1'b0;
    case (w_mode_nxt)
      c_mode_clear: w_clear_nxt = 1'b1;
      c_mode_run: begin
        case (w_code_nxt)
          3'b011:  w_ns_nxt = c_grn;
          3'b010:  w_ns_nxt = c_yel;
          3'b000:  w_ew_nxt = c_grn;
          3'b001:  w_ew_nxt = c_yel;
          default: ;
        endcase
      end
      c_mode_flash: begin
        w_ns_nxt = {1'b0, w_phase_nxt, 1'b0};
        w_ew_nxt = {1'b0, w_phase_nxt, 1'b0};
      end
      default: ;
    endcase
  end

  assign lamp_bus.o_ns_lamp = r_ns_lamp;
  assign lamp_bus.o_ew_lamp = r_ew_lamp;
  assign lamp_bus.o_clear   = r_clear;
  assign lamp_bus.o_fault   = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_tl_lamp_driver.sv
//------------------------------------------------------------------------------
// tb_tl_lamp_driver : directed self-checking bench for tl_lamp_driver
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tl_lamp_driver;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  tl_lamp_driver_if u_if_a ();
  tl_lamp_driver_if u_if_b ();

  tl_lamp_driver #(.T_WIDTH(8), .CLR_TIME(8'd2), .BLINK_HALF(8'd4)) u_dut_a (
    .i_clk    (clk),
    .i_rst    (rst),
    .lamp_bus (u_if_a.slave)
  );

  tl_lamp_driver #(.T_WIDTH(8), .CLR_TIME(8'd0), .BLINK_HALF(8'd1)) u_dut_b (
    .i_clk    (clk),
    .i_rst    (rst),
    .lamp_bus (u_if_b.slave)
  );

  // {ns, ew, clear, fault}
  logic [7:0] obs_a;
  logic [7:0] obs_b;
  assign obs_a = {u_if_a.o_ns_lamp, u_if_a.o_ew_lamp, u_if_a.o_clear, u_if_a.o_fault};
  assign obs_b = {u_if_b.o_ns_lamp, u_if_b.o_ew_lamp, u_if_b.o_clear, u_if_b.o_fault};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] exp;
    rst = 1'b1;
    u_if_a.i_state = 3'b111;
    u_if_b.i_state = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {R, R, 2'b00};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs_a, exp);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp = ((i % 8) < 4) ? {Y, Y, 2'b00} : {OFF, OFF, 2'b00};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL start_flash[%0d]: got %b expected %b", i, obs_a, exp);
      end
    end
  endtask

  task automatic test_clear_to_green;
    logic [7:0] exp;
    u_if_a.i_state = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (i < 2) ? {R, R, 2'b10} : {G, R, 2'b00};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL clear_to_green[%0d]: got %b expected %b", i, obs_a, exp);
      end
    end
  endtask

  task automatic test_sequence;
    logic [7:0] exp;
    logic [2:0] code;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       legal;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       code = 3'b010;
        1:       code = 3'b000;
        2:       code = 3'b001;
        default: code = 3'b011;
      endcase
      u_if_a.i_state = code;
      for (int j = 0; j < 10; j++) begin
        tick();
        case (code)
          3'b010:  exp = {Y, R, 2'b00};
          3'b001:  exp = {R, Y, 2'b00};
          3'b000:  exp = (j < 2) ? {R, R, 2'b10} : {R, G, 2'b00};
          default: exp = (j < 2) ? {R, R, 2'b10} : {G, R, 2'b00};
        endcase
        vectors++;
        if (obs_a !== exp) begin
          miscompares++;
          $display("FAIL sequence[%0d/%0d] code %b: got %b expected %b", s, j, code, obs_a, exp);
        end
        ns = u_if_a.o_ns_lamp;
        ew = u_if_a.o_ew_lamp;
        legal = $onehot0(ns) && $onehot0(ew) && !(ns[0] && ew[0])
                && !((ns[0] || ew[0]) && (ns[1] || ew[1]));
        vectors++;
        if (!legal) begin
          miscompares++;
          $display("FAIL illegal_lamps[%0d/%0d]: got ns=%b ew=%b required a legal pair", s, j, ns, ew);
        end
      end
    end
  endtask

  task automatic test_clear_restart;
    logic [7:0] exp;
    // Clearance toward EW green, interrupted by a new green after one red cycle.
    u_if_a.i_state = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) u_if_a.i_state = 3'b011;
      exp = (i < 3) ? {R, R, 2'b10} : {G, R, 2'b00};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL clear_restart[%0d]: got %b expected %b", i, obs_a, exp);
      end
    end
    // Same interruption, but by a yellow code: leaves clearance at once.
    u_if_a.i_state = 3'b000;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) u_if_a.i_state = 3'b001;
      exp = (i == 0) ? {R, R, 2'b10} : {R, Y, 2'b00};
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL clear_to_yellow[%0d]: got %b expected %b", i, obs_a, exp);
      end
    end
  endtask

  task automatic test_fault;
    logic [7:0] exp;
    u_if_a.i_state = 3'b101;
    for (int i = 0; i < 5; i++) begin
      tick();
      case (i)
        0:       begin exp = {Y, Y, 2'b01}; u_if_a.i_state = 3'b011; end
        1, 2:    exp = {R, R, 2'b11};
        3:       begin exp = {G, R, 2'b01}; u_if_a.i_state = 3'b000; end
        default: exp = {R, R, 2'b11};
      endcase
      vectors++;
      if (obs_a !== exp) begin
        miscompares++;
        $display("FAIL fault[%0d]: got %b expected %b", i, obs_a, exp);
      end
    end
    // Reset mid-clearance wins and clears the sticky fault.
    rst = 1'b1;
    tick();
    exp = {R, R, 2'b00};
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got %b expected %b", obs_a, exp);
    end
    rst = 1'b0;
    tick();
    exp = {R, R, 2'b10};
    vectors++;
    if (obs_a !== exp) begin
      miscompares++;
      $display("FAIL after_reset_clear: got %b expected %b", obs_a, exp);
    end
  endtask

  task automatic test_no_clear_fast_blink;
    logic [7:0] exp;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       u_if_b.i_state = 3'b010;
        1:       u_if_b.i_state = 3'b000;
        2:       u_if_b.i_state = 3'b011;
        default: u_if_b.i_state = 3'b111;
      endcase
      tick();
      case (i)
        0:       exp = {Y, R, 2'b00};
        1:       exp = {R, G, 2'b00};
        2:       exp = {G, R, 2'b00};
        default: exp = (i % 2 == 1) ? {Y, Y, 2'b00} : {OFF, OFF, 2'b00};
      endcase
      vectors++;
      if (obs_b !== exp) begin
        miscompares++;
        $display("FAIL no_clear_fast_blink[%0d]: got %b expected %b", i, obs_b, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    u_if_a.i_state = 3'b111;
    u_if_b.i_state = 3'b111;
    test_reset();
    test_clear_to_green();
    test_sequence();
    test_clear_restart();
    test_fault();
    test_no_clear_fast_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
